// File: rtl/controle_microondas_pkg.sv
// Shared definitions for the microwave controller: state encoding,
// production default timing and a counter-width helper.
package controle_microondas_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int TICK_DIV_DEF    = 50_000_000;
  localparam int BEEP_CYCLES_DEF = 100_000_000;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controle_microondas_divisor_tick.sv
// Countdown step divider: counts 0..TICK_DIV-1 while run is high and
// flags the last count. Dropping run returns the count to zero.
import controle_microondas_pkg::*;

module divisor_tick #(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic clearn,
  input  logic run,
  output logic tick
);

  localparam int                 CW   = cnt_width(TICK_DIV);
  localparam logic [CW-1:0]      LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/controle_microondas.sv
// Microwave controller: sequences IDLE/RUN/PAUSE/DONE, paces the digit
// counters with a one-step enable, and drives magnetron and buzzer.
import controle_microondas_pkg::*;

module controle_microondas #(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int BEEP_CYCLES = BEEP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       zero,
  output logic       load,
  output logic       en,
  output logic       cnt_clearn,
  output logic       mag_on,
  output logic       beep,
  output logic [1:0] state
);

  localparam int            BW        = cnt_width(BEEP_CYCLES + 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_stop_d;
  logic          r_clr_n;
  logic [BW-1:0] r_beep_cnt;
  logic          w_stop_rise;
  logic          w_clr_req;
  logic          w_div_run;
  logic          w_tick;

  assign w_stop_rise = stop & ~r_stop_d;

  // Divider only runs while RUN is kept, so it restarts from zero on every entry.
  assign w_div_run = (r_state == S_RUN) && (w_next == S_RUN);

  divisor_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk    (clk),
    .clearn (clearn),
    .run    (w_div_run),
    .tick   (w_tick)
  );

  always_comb begin
    w_next    = r_state;
    w_clr_req = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_stop_rise) begin
          w_clr_req = 1'b1;
        end else if (door_closed && start && !zero) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // A finished cook beats a simultaneous pause request.
        if (zero) begin
          w_next = S_DONE;
        end else if (stop || !door_closed) begin
          w_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_stop_rise) begin
          w_next    = S_IDLE;
          w_clr_req = 1'b1;
        end else if (door_closed && start && !stop) begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (w_stop_rise || !door_closed) begin
          w_next = S_IDLE;
        end else if (r_beep_cnt == BEEP_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_state  <= S_IDLE;
      r_stop_d <= 1'b0;
      r_clr_n  <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_stop_d <= stop;
      r_clr_n  <= ~w_clr_req;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_beep_cnt <= '0;
    end else if ((r_state == S_DONE) && (w_next == S_DONE)) begin
      r_beep_cnt <= r_beep_cnt + 1'b1;
    end else begin
      r_beep_cnt <= '0;
    end
  end

  // No step is issued while counters are at zero or in the cycle RUN is left.
  assign en         = (r_state == S_RUN) && w_tick && !zero && !stop && door_closed;
  assign load       = (r_state == S_IDLE) ? ~key_valid : 1'b1;
  assign cnt_clearn = r_clr_n;
  assign mag_on     = (r_state == S_RUN);
  assign beep       = (r_state == S_DONE);
  assign state      = r_state;

endmodule

// File: tb/tb_controle_microondas.sv
// Directed bench for controle_microondas with TICK_DIV=4, BEEP_CYCLES=3:
// one table row per clock cycle, plus a hand sequence for async reset.
module tb_controle_microondas;

  logic       clk;
  logic       clearn;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       key_valid;
  logic       zero;
  logic       load;
  logic       en;
  logic       cnt_clearn;
  logic       mag_on;
  logic       beep;
  logic [1:0] state;

  int n_total;
  int n_pass;

  typedef struct {
    logic       st, sp, dc, kv, z;
    logic       ld, en, cl, mg, bp;
    logic [1:0] s;
  } vec_t;

  vec_t tv[$];

  controle_microondas #(
    .TICK_DIV    (4),
    .BEEP_CYCLES (3)
  ) dut (
    .clk         (clk),
    .clearn      (clearn),
    .start       (start),
    .stop        (stop),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .zero        (zero),
    .load        (load),
    .en          (en),
    .cnt_clearn  (cnt_clearn),
    .mag_on      (mag_on),
    .beep        (beep),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic st, sp, dc, kv, z,
                     input logic ld, e, cl, mg, bp, input logic [1:0] s);
    vec_t v;
    v.st = st; v.sp = sp; v.dc = dc; v.kv = kv; v.z = z;
    v.ld = ld; v.en = e; v.cl = cl; v.mg = mg; v.bp = bp; v.s = s;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [1:0] got, input logic [1:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_all(input int idx, input logic ld, e, cl, mg, bp,
                         input logic [1:0] s);
    chk("load", idx, {1'b0, load}, {1'b0, ld});
    chk("en", idx, {1'b0, en}, {1'b0, e});
    chk("cnt_clearn", idx, {1'b0, cnt_clearn}, {1'b0, cl});
    chk("mag_on", idx, {1'b0, mag_on}, {1'b0, mg});
    chk("beep", idx, {1'b0, beep}, {1'b0, bp});
    chk("state", idx, state, s);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clearn = 1'b0; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; key_valid = 1'b0; zero = 1'b0;

    // keypad strobe in IDLE
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,1,0, 0,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);
    // start, three steps, then zero ends the cook
    add(1,0,1,0,0, 1,0,1,0,0,2'd0);
    for (int k = 1; k <= 12; k++)
      add(0,0,1,(k == 2),0, 1,(k % 4 == 0),1,1,0,2'd1);
    add(0,0,1,0,1, 1,0,1,1,0,2'd1);
    add(0,0,1,0,1, 1,0,1,0,1,2'd3);
    add(0,0,1,0,1, 1,0,1,0,1,2'd3);
    add(0,0,1,0,1, 1,0,1,0,1,2'd3);
    add(0,0,1,0,1, 1,0,1,0,0,2'd0);
    // start ignored with zero set or door open
    add(1,0,1,0,1, 1,0,1,0,0,2'd0);
    add(0,0,1,0,1, 1,0,1,0,0,2'd0);
    add(1,0,0,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);
    // door opens mid-period, resume restarts the divider
    add(1,0,1,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,0,0,0, 1,0,1,1,0,2'd1);
    add(0,0,0,0,0, 1,0,1,0,0,2'd2);
    add(1,0,1,0,0, 1,0,1,0,0,2'd2);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,1,1,1,0,2'd1);
    // stop pauses; held stop does not cancel; fresh press does
    add(0,1,1,0,0, 1,0,1,1,0,2'd1);
    add(0,1,1,0,0, 1,0,1,0,0,2'd2);
    add(0,1,1,0,0, 1,0,1,0,0,2'd2);
    add(0,0,1,0,0, 1,0,1,0,0,2'd2);
    add(0,1,1,0,0, 1,0,1,0,0,2'd2);
    add(0,1,1,0,0, 1,0,0,0,0,2'd0);
    add(0,1,1,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);
    add(0,1,1,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,0,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);
    // start+stop in PAUSE: stop wins
    add(1,0,1,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,0,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,0,1,0,0,2'd2);
    add(1,1,1,0,0, 1,0,1,0,0,2'd2);
    add(0,0,1,0,0, 1,0,0,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);
    // zero+stop at a tick: no en, DONE; door open cuts the beep
    add(1,0,1,0,0, 1,0,1,0,0,2'd0);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,0,1,0,0, 1,0,1,1,0,2'd1);
    add(0,1,1,0,1, 1,0,1,1,0,2'd1);
    add(0,1,1,0,1, 1,0,1,0,1,2'd3);
    add(0,0,0,0,1, 1,0,1,0,1,2'd3);
    add(0,0,1,0,0, 1,0,1,0,0,2'd0);

    // reset values while clearn is held low
    repeat (2) @(negedge clk);
    #1;
    chk_all(-1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    clearn = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      start = tv[i].st; stop = tv[i].sp; door_closed = tv[i].dc;
      key_valid = tv[i].kv; zero = tv[i].z;
      #1;
      chk_all(i, tv[i].ld, tv[i].en, tv[i].cl, tv[i].mg, tv[i].bp, tv[i].s);
    end

    // asynchronous reset in RUN drops mag_on before the next edge
    @(negedge clk);
    start = 1'b1; stop = 1'b0; door_closed = 1'b1; key_valid = 1'b0; zero = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mag_on_run", 100, {1'b0, mag_on}, 2'd1);
    chk("state_run", 100, state, 2'd1);
    #2;
    clearn = 1'b0;
    #1;
    chk_all(101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    clearn = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
